// File: rtl/rr_grant_arbiter.sv
// Purpose: round-robin arbiter that grants one of NUM_REQ requesters a shared decoder/mux resource (index + one-hot).
// Latency: request to grant is 1 cycle; holder drop to grant removal (or zero-bubble handover) is 1 cycle.
// Backpressure: the holder keeps the grant while its req stays high; enable low only blocks new grants.
// Optional build macro ARB_HOLD_LIMIT_EN caps a contiguous hold at MAX_HOLD cycles by forcing a release.
module rr_grant_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_LIMIT_ON = 1'b1;
`else
    localparam bit HOLD_LIMIT_ON = 1'b0;
`endif

    // hold_cnt is zero in the first grant cycle, so MAX_HOLD-1 marks the last allowed cycle
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;

    logic [IDX_W-1:0] rel_ptr;
    logic             holder_req;
    logic             force_rel;
    logic             release_now;
    logic [IDX_W:0]   pick_idle;
    logic [IDX_W:0]   pick_rel;

    // First set request scanning start, start+1, ... with wrap; returns {found, index}.
    // Walking the offsets from high to low lets the smallest offset overwrite the result last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   start);
        logic [IDX_W:0] res;
        int unsigned    pos;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = (int'(start) + k) % NUM_REQ;
            if (r[pos]) begin
                res = {1'b1, IDX_W'(pos)};
            end
        end
        return res;
    endfunction

    // Release bookkeeping and the two candidate searches (fresh start vs. handover)
    always_comb begin
        rel_ptr     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        holder_req  = req[gnt_idx];
        force_rel   = HOLD_LIMIT_ON && holder_req && (hold_cnt == HOLD_LAST);
        release_now = !holder_req || force_rel;
        pick_idle   = rr_pick(req, ptr);
        pick_rel    = rr_pick(req, rel_ptr);
    end

    // Arbitration FSM: grant from IDLE, hold or hand over in BUSY
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && pick_idle[IDX_W]) begin
                        gnt_idx   <= pick_idle[IDX_W-1:0];
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr <= rel_ptr;
                        if (enable && pick_rel[IDX_W]) begin
                            // zero-bubble handover; may re-grant the same holder on a forced release
                            gnt_idx  <= pick_rel[IDX_W-1:0];
                            hold_cnt <= '0;
                        end else begin
                            gnt_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    // One-hot decode of the registered index, qualified by the registered valid
    always_comb begin
        gnt = '0;
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int MH = 8;

`ifdef ARB_HOLD_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         gnt_valid;

    always #5 clk = ~clk;

    rr_grant_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (W),
        .MAX_HOLD(MH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: holder = -1 when nothing is granted, held = cycles granted so far
    int m_holder = -1;
    int m_ptr    = 0;
    int m_held   = 0;

    typedef struct {
        logic         rst;
        logic         en;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic         vld;
        logic [W-1:0] idx;
    } vec_t;

    vec_t tbl[$];

    function automatic int m_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic [N-1:0] r);
        if (rst) begin
            m_holder = -1;
            m_ptr    = 0;
            m_held   = 0;
        end else if (m_holder < 0) begin
            if (en && r != 0) begin
                m_holder = m_pick(r, m_ptr);
                m_held   = 1;
            end
        end else if (!r[m_holder] || (LIM && m_held >= MH)) begin
            m_ptr = (m_holder + 1) % N;
            if (en && r != 0) begin
                m_holder = m_pick(r, m_ptr);
                m_held   = 1;
            end else begin
                m_holder = -1;
            end
        end else begin
            m_held++;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge
    task automatic drive(input logic rst, input logic en, input logic [N-1:0] r);
        @(negedge clk);
        reset  = rst;
        enable = en;
        req    = r;
        @(posedge clk);
        #1;
        cyc++;
        model_step(rst, en, r);
    endtask

    task automatic check_model();
        int exp_gnt;
        exp_gnt = (m_holder < 0) ? 0 : (1 << m_holder);
        check("rand_gnt", int'(gnt), exp_gnt);
        check("rand_valid", int'(gnt_valid), (m_holder < 0) ? 0 : 1);
        if (m_holder >= 0) check("rand_idx", int'(gnt_idx), m_holder);
    endtask

    task automatic add(input logic rst, input logic en, input logic [N-1:0] r,
                       input logic [N-1:0] g, input logic v, input logic [W-1:0] i);
        vec_t e;
        e.rst = rst; e.en = en; e.req = r; e.gnt = g; e.vld = v; e.idx = i;
        tbl.push_back(e);
    endtask

    initial begin
        logic [N-1:0] r;
        int           exp_h;

        reset  = 1'b1;
        enable = 1'b0;
        req    = '0;

        // reset with all requesting
        add(1, 1, 4'b1111, 4'b0000, 0, 0);
        add(1, 1, 4'b1111, 4'b0000, 0, 0);
        add(0, 1, 4'b1111, 4'b0001, 1, 0);
        // rotation, each holder drops for one cycle
        add(0, 1, 4'b1110, 4'b0010, 1, 1);
        add(0, 1, 4'b1101, 4'b0100, 1, 2);
        add(0, 1, 4'b1011, 4'b1000, 1, 3);
        add(0, 1, 4'b0111, 4'b0001, 1, 0);
        // get requester 2, release it so ptr=3, then only 1 requests
        add(0, 1, 4'b0100, 4'b0100, 1, 2);
        add(0, 1, 4'b0010, 4'b0010, 1, 1);
        add(0, 1, 4'b0000, 4'b0000, 0, 0);
        // enable gating with holder 2
        add(0, 1, 4'b0100, 4'b0100, 1, 2);
        add(0, 0, 4'b0100, 4'b0100, 1, 2);
        add(0, 0, 4'b1001, 4'b0000, 0, 0);
        add(0, 0, 4'b1001, 4'b0000, 0, 0);
        add(0, 1, 4'b1001, 4'b1000, 1, 3);
        // build ptr=3 with an active grant, then reset mid-grant
        add(0, 1, 4'b0000, 4'b0000, 0, 0);
        add(0, 1, 4'b0010, 4'b0010, 1, 1);
        add(0, 1, 4'b0100, 4'b0100, 1, 2);
        add(0, 1, 4'b1000, 4'b1000, 1, 3);
        add(1, 1, 4'b1100, 4'b0000, 0, 0);
        add(0, 1, 4'b1100, 4'b0100, 1, 2);
        // request that vanishes while disabled is not latched
        add(0, 1, 4'b0000, 4'b0000, 0, 0);
        add(0, 0, 4'b0001, 4'b0000, 0, 0);
        add(0, 1, 4'b0000, 4'b0000, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].req);
            check($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            check($sformatf("vec%0d_valid", i), int'(gnt_valid), int'(tbl[i].vld));
            if (tbl[i].vld || tbl[i].rst)
                check($sformatf("vec%0d_idx", i), int'(gnt_idx), int'(tbl[i].idx));
        end

        // two requesters held continuously: alternation every MH cycles only with the limit
        drive(1, 1, 4'b0000);
        drive(1, 1, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            drive(0, 1, 4'b0011);
            exp_h = LIM ? ((c / MH) % 2) : 0;
            check($sformatf("hold2_c%0d", c), int'(gnt), 1 << exp_h);
        end
        // sole requester is never interrupted
        for (int c = 0; c < 20; c++) begin
            drive(0, 1, 4'b0001);
            check($sformatf("hold1_gnt_c%0d", c), int'(gnt), 1);
            check($sformatf("hold1_valid_c%0d", c), int'(gnt_valid), 1);
        end

        // randomized traffic against the model
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            logic rst_b;
            logic en_b;
            rst_b = ($urandom_range(0, 199) == 0);
            en_b  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            drive(rst_b, en_b, r);
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
